// File: rtl/zap_inv_sequencer_pkg.sv
// Shared types for the cache/TLB invalidation sequencer.
// State encodings, valid-bit polarity and width helpers.
package zap_inv_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP_C = 2'd1,
    SWEEP_T = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic VALID_CLR = 1'b0;
  localparam logic VALID_SET = 1'b1;

  function automatic int max_w(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zap_inv_sequencer_if.sv
// Command, fill-arbitration and RAM-write bundle of the
// invalidation sequencer.
interface zap_inv_sequencer_if #(
  parameter int CACHE_LINES = 64,
  parameter int TLB_ENTRIES = 32
);
  localparam int CW = $clog2(CACHE_LINES);
  localparam int TW = $clog2(TLB_ENTRIES);

  logic          cache_inv;
  logic          tlb_inv;
  logic          fill_req;
  logic [CW-1:0] fill_index;
  logic          fill_gnt;
  logic          tag_wr_en;
  logic [CW-1:0] tag_wr_index;
  logic          tag_wr_valid;
  logic          tlb_wr_en;
  logic [TW-1:0] tlb_wr_index;
  logic          busy;
  logic          done;

  modport master (
    output cache_inv, tlb_inv,
    output fill_req, fill_index,
    input  fill_gnt,
    input  tag_wr_en, tag_wr_index,
    input  tag_wr_valid,
    input  tlb_wr_en, tlb_wr_index,
    input  busy, done
  );

  modport slave (
    input  cache_inv, tlb_inv,
    input  fill_req, fill_index,
    output fill_gnt,
    output tag_wr_en, tag_wr_index,
    output tag_wr_valid,
    output tlb_wr_en, tlb_wr_index,
    output busy, done
  );

endinterface

// File: rtl/zap_inv_counter.sv
// Loadable sweep index counter with terminal-count compare.
// q_next exposes the upcoming value for registered outputs.
module zap_inv_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] q,
  output logic [W-1:0] q_next,
  output logic         tc
);

  always_comb begin
    q_next = q;
    if (load)
      q_next = '0;
    else if (inc)
      q_next = q + 1'b1;
  end

  assign tc = (q == term);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else
      q <= q_next;
  end

endmodule

// File: rtl/zap_inv_sequencer.sv
// Sweeps cache tags and TLB entries invalid on CP15 commands,
// sharing the tag write port with the line-fill unit.
module zap_inv_sequencer
  import zap_inv_sequencer_pkg::*;
#(
  parameter int CACHE_LINES = 64,
  parameter int TLB_ENTRIES = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  zap_inv_sequencer_if.slave bus
);

  localparam int CW = $clog2(CACHE_LINES);
  localparam int TW = $clog2(TLB_ENTRIES);
  localparam int NW = max_w(CW, TW);
  localparam logic [NW-1:0] C_LAST =
    NW'(CACHE_LINES - 1);
  localparam logic [NW-1:0] T_LAST =
    NW'(TLB_ENTRIES - 1);

  state_t        state, state_n;
  logic          pend_c, pend_c_n;
  logic          pend_t, pend_t_n;
  logic          ld, inc, tc;
  logic [NW-1:0] term, cnt, cnt_n;
  logic          start_c, start_t, fill_ok;

  logic          gnt_q, gnt_n;
  logic          tag_en_q, tag_en_n;
  logic [CW-1:0] tag_idx_q, tag_idx_n;
  logic          tag_val_q, tag_val_n;
  logic          tlb_en_q, tlb_en_n;
  logic [TW-1:0] tlb_idx_q, tlb_idx_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  zap_inv_counter #(.W(NW)) u_cnt (
    .clk    (i_clk),
    .reset  (i_reset),
    .load   (ld),
    .inc    (inc),
    .term   (term),
    .q      (cnt),
    .q_next (cnt_n),
    .tc     (tc)
  );

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    inc     = 1'b0;
    term    = (state == SWEEP_T) ? T_LAST : C_LAST;
    unique case (state)
      IDLE: begin
        if (pend_c) begin
          state_n = SWEEP_C;
          ld      = 1'b1;
        end else if (pend_t) begin
          state_n = SWEEP_T;
          ld      = 1'b1;
        end
      end
      SWEEP_C: begin
        if (tc) begin
          ld      = 1'b1;
          state_n = pend_t ? SWEEP_T : DONE;
        end else begin
          inc = 1'b1;
        end
      end
      SWEEP_T: begin
        if (tc) begin
          ld      = 1'b1;
          state_n = pend_c ? SWEEP_C : DONE;
        end else begin
          inc = 1'b1;
        end
      end
      DONE: state_n = IDLE;
    endcase
  end

  // Outputs are registered images of the upcoming state,
  // so a write appears in the same cycle as its sweep state.
  always_comb begin
    start_c  = (state_n == SWEEP_C) && (state != SWEEP_C);
    start_t  = (state_n == SWEEP_T) && (state != SWEEP_T);
    pend_c_n = (pend_c & ~start_c) | bus.cache_inv;
    pend_t_n = (pend_t & ~start_t) | bus.tlb_inv;
    fill_ok  = (state == IDLE) & ~pend_c & ~pend_t
             & bus.fill_req;
    gnt_n     = fill_ok;
    tag_en_n  = fill_ok | (state_n == SWEEP_C);
    tag_idx_n = '0;
    if (fill_ok)
      tag_idx_n = bus.fill_index;
    else if (state_n == SWEEP_C)
      tag_idx_n = CW'(cnt_n);
    tag_val_n = fill_ok ? VALID_SET : VALID_CLR;
    tlb_en_n  = (state_n == SWEEP_T);
    tlb_idx_n = tlb_en_n ? TW'(cnt_n) : '0;
    done_n    = (state_n == DONE);
    busy_n    = pend_c_n | pend_t_n | (state_n != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      pend_c    <= 1'b0;
      pend_t    <= 1'b0;
      gnt_q     <= 1'b0;
      tag_en_q  <= 1'b0;
      tag_idx_q <= '0;
      tag_val_q <= 1'b0;
      tlb_en_q  <= 1'b0;
      tlb_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      pend_c    <= pend_c_n;
      pend_t    <= pend_t_n;
      gnt_q     <= gnt_n;
      tag_en_q  <= tag_en_n;
      tag_idx_q <= tag_idx_n;
      tag_val_q <= tag_val_n;
      tlb_en_q  <= tlb_en_n;
      tlb_idx_q <= tlb_idx_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign bus.fill_gnt     = gnt_q;
  assign bus.tag_wr_en    = tag_en_q;
  assign bus.tag_wr_index = tag_idx_q;
  assign bus.tag_wr_valid = tag_val_q;
  assign bus.tlb_wr_en    = tlb_en_q;
  assign bus.tlb_wr_index = tlb_idx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_zap_inv_sequencer.sv
// Directed and random checks of the invalidation sequencer
// against a queue-of-planned-writes reference model.
module tb_zap_inv_sequencer;

  localparam int C = 4;
  localparam int T = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   dones;

  zap_inv_sequencer_if #(
    .CACHE_LINES(C), .TLB_ENTRIES(T)
  ) bus ();

  zap_inv_sequencer #(
    .CACHE_LINES(C), .TLB_ENTRIES(T)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 1 = tag clear, 2 = tlb clear, 3 = done
  typedef struct {
    int kind;
    int idx;
  } rec_t;

  rec_t plan[$];
  rec_t cur;
  bit   cur_act;
  bit   pc, pt;
  logic e_gnt, e_tag_en, e_tag_val;
  logic e_tlb_en, e_busy, e_done;
  logic [7:0] e_tag_idx, e_tlb_idx;

  function automatic void push_sweep(int kind, int n);
    for (int i = 0; i < n; i++) begin
      rec_t r;
      r.kind = kind;
      r.idx  = i;
      plan.push_back(r);
    end
  endfunction

  function automatic void model(bit r, bit ci, bit ti,
                                bit fr, logic [1:0] fi);
    bit nfill;
    nfill = 1'b0;
    if (r) begin
      plan.delete();
      cur_act = 1'b0;
      pc = 1'b0;
      pt = 1'b0;
      {e_gnt, e_tag_en, e_tag_val} = 3'b000;
      {e_tlb_en, e_busy, e_done} = 3'b000;
      e_tag_idx = '0;
      e_tlb_idx = '0;
      return;
    end
    if (!cur_act) begin
      if (pc) begin
        pc = 1'b0;
        push_sweep(1, C);
      end else if (pt) begin
        pt = 1'b0;
        push_sweep(2, T);
      end else if (fr) begin
        nfill = 1'b1;
      end
    end else if (plan.size() == 0) begin
      if (cur.kind == 1 && pt) begin
        pt = 1'b0;
        push_sweep(2, T);
      end else if (cur.kind == 2 && pc) begin
        pc = 1'b0;
        push_sweep(1, C);
      end else if (cur.kind != 3) begin
        push_sweep(3, 1);
      end
    end
    if (plan.size() != 0) begin
      cur = plan.pop_front();
      cur_act = 1'b1;
    end else begin
      cur_act = 1'b0;
    end
    pc = pc | ci;
    pt = pt | ti;
    e_gnt     = nfill;
    e_tag_en  = nfill | (cur_act && cur.kind == 1);
    e_tag_val = nfill;
    e_tag_idx = nfill ? 8'(fi) :
      ((cur_act && cur.kind == 1) ? 8'(cur.idx) : 8'd0);
    e_tlb_en  = cur_act && cur.kind == 2;
    e_tlb_idx = e_tlb_en ? 8'(cur.idx) : 8'd0;
    e_done    = cur_act && cur.kind == 3;
    e_busy    = pc | pt | cur_act;
  endfunction

  task automatic chk(string tag, logic [7:0] got,
                     logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("fill_gnt", 8'(bus.fill_gnt), 8'(e_gnt));
    chk("tag_wr_en", 8'(bus.tag_wr_en), 8'(e_tag_en));
    chk("tag_wr_index", 8'(bus.tag_wr_index), e_tag_idx);
    chk("tag_wr_valid", 8'(bus.tag_wr_valid),
        8'(e_tag_val));
    chk("tlb_wr_en", 8'(bus.tlb_wr_en), 8'(e_tlb_en));
    chk("tlb_wr_index", 8'(bus.tlb_wr_index), e_tlb_idx);
    chk("busy", 8'(bus.busy), 8'(e_busy));
    chk("done", 8'(bus.done), 8'(e_done));
  endtask

  task automatic cyc(bit r, bit ci, bit ti, bit fr,
                     logic [1:0] fi);
    rst            = r;
    bus.cache_inv  = ci;
    bus.tlb_inv    = ti;
    bus.fill_req   = fr;
    bus.fill_index = fi;
    @(posedge clk);
    model(r, ci, ti, fr, fi);
    #1;
    check_all();
    if (bus.done === 1'b1)
      dones++;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dones       = 0;
    cur_act     = 1'b0;
    pc          = 1'b0;
    pt          = 1'b0;
    rst            = 1'b1;
    bus.cache_inv  = 1'b0;
    bus.tlb_inv    = 1'b0;
    bus.fill_req   = 1'b0;
    bus.fill_index = 2'd0;

    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(3);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(9);

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(14);

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    idle(2);

    dones = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(12);
    chk("done_count_repulse", 8'(dones), 8'd2);

    dones = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(6);
    chk("done_count_reset", 8'(dones), 8'd0);

    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);

    repeat (400) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 24) == 0,
          1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
